snn_window_classifier: RTL and testbench
========================================

# snn_window_classifier

Parametrised spiking classifier core for the next tapeout. A byte-wide input stream drives NUM_NEURONS weighted synapses into adaptive-threshold leaky integrate-and-fire neurons, and each neuron counts its spikes over a fixed window of accepted samples. A sequential argmax then produces one registered class/score result per window under a start/done handshake. Compared with the current free-running readout, this block:

- clears its state per window,
- saturates all arithmetic instead of wrapping,
- breaks ties deterministically.

## Interface
- NUM_NEURONS, 10: neuron/class count, 2..32
- WIDTH_P, 8: input sample width
- WINDOW_LEN, 64: accepted samples per classification window, ≥1
- WEIGHTS, all 4'd1: packed NUM_NEURONS×4-bit unsigned synapse gains, neuron i at bits [4i+3:4i]
- THRESHOLD, 128: initial firing threshold
- THRESHOLD_INC, 20: threshold increase on a spike
- THRESHOLD_DEC, 1: threshold decrease on a non-spike sample
- THRESHOLD_MIN, 75: threshold floor
- LEAK_SHIFT, 3: membrane leak, v − (v >> LEAK_SHIFT)
- clk_i  in  1  clock, all state on rising edge
- rst_ni  in  1  reset; asynchronous, active-low
- start_i  in  1  begin a window (honoured only in IDLE)
- data_i  in  WIDTH_P  input sample
- data_valid_i  in  1  data_i valid (consumed only in RUN)
- busy_o  out  1  high in RUN and SCAN
- done_o  out  1  one-cycle pulse when the result updates
- class_o  out  $clog2(NUM_NEURONS)  winning neuron index
- score_o  out  $clog2(WINDOW_LEN+1)  winner spike count
- spikes_o  out  NUM_NEURONS  per-neuron spike flags for the current accepted sample, registered

## Operation
- FSM states:
  - IDLE: start_i → RUN.
  - RUN: after the WINDOW_LEN-th accepted sample → SCAN.
  - SCAN: after NUM_NEURONS cycles → DONE.
  - DONE: → IDLE unconditionally.
- On the IDLE→RUN edge:
  - membranes v_i := 0
  - thresholds thr_i := THRESHOLD
  - spike counts c_i := 0
  - sample counter := 0
- Synapse: cur_i = min(data_i × W_i, 2^WIDTH_P − 1).
- Neuron, evaluated only on RUN cycles with data_valid_i=1. Membrane and threshold are WIDTH_P+1 bits wide.
  - s = sat(v_i − (v_i >> LEAK_SHIFT) + cur_i), clamped at 2^(WIDTH_P+1) − 1.
  - If s ≥ thr_i: spike; v_i := 0; thr_i := min(thr_i + THRESHOLD_INC, 2^(WIDTH_P+1) − 1); c_i += 1.
  - Else: v_i := s; thr_i := max(thr_i − THRESHOLD_DEC, THRESHOLD_MIN).
- RUN cycles with data_valid_i=0 leave all neuron state unchanged (no leak, no threshold decay).
- c_i cannot exceed WINDOW_LEN, so counts need no saturation.
- SCAN visits one neuron per cycle, index 0 → NUM_NEURONS−1.
  - The running best is replaced only when c_i > best (strict), so on a tie the lowest index wins.
  - If every count is 0, the result is class 0, score 0.
- DONE: class_o and score_o load from the running best and done_o=1. Both outputs hold until the next DONE.
- start_i outside IDLE is ignored; it is neither queued nor able to restart the window.
- data_valid_i outside RUN is ignored.

## Timing
- Reset (asynchronous assert, synchronous deassert by the integrator) sets:
  - state IDLE
  - busy_o=0, done_o=0, class_o=0, score_o=0, spikes_o=0
  - all v_i, thr_i and c_i to their IDLE→RUN values
- With start_i sampled at edge 0 and data_valid_i held high:
  - samples are accepted on edges 1..WINDOW_LEN;
  - SCAN occupies the next NUM_NEURONS cycles;
  - done_o is high in the cycle after edge WINDOW_LEN+NUM_NEURONS+1.
- Gaps in data_valid_i lengthen RUN cycle-for-cycle.
- busy_o goes high the cycle after start_i is sampled and low in the DONE cycle.
- A new start_i is accepted on the cycle after DONE, giving back-to-back windows.
- spikes_o updates one cycle after each accepted sample and clears to 0 on any non-accepting cycle.
- A reset asserted mid-RUN or mid-SCAN aborts the window: no done_o, and outputs return to their reset values immediately.

## Test plan
- Zero input, NUM_NEURONS=10, WINDOW_LEN=8, all weights 1, data_i=0 continuous, start at edge 0:
  - done_o pulses in the cycle after edge 19;
  - class_o=0, score_o=0;
  - busy_o high for exactly 18 cycles.
- Weighted winner, W_3=2, other weights 1, data_i=64, WINDOW_LEN=8:
  - neuron 3 spikes on accepted sample 1 (cur 128 ≥ 128);
  - class_o=3 and score_o equals neuron 3's reference-model count, which is greater than every other count.
- Tie-break, all weights 1, data_i=200:
  - all counts are equal;
  - class_o=0, score_o equals the model count (4 after the first 4 samples of a 4-sample window).
- Saturation, W_0=15, data_i=255:
  - cur_0=255, not wrapped;
  - thr_0 never exceeds 511, v_0 never wraps, and the model matches every cycle.
- Handshake:
  - data_valid_i toggled 1/0 lengthens RUN to 2×WINDOW_LEN−1 cycles;
  - start_i pulsed during RUN and SCAN changes nothing;
  - a back-to-back start the cycle after DONE produces a second correct result.
- Reset mid-RUN (rst_ni low for 1 cycle at sample 5):
  - all outputs go to 0 asynchronously;
  - no done_o;
  - a fresh window afterwards matches the model from clean state.

Source files
------------

// File: rtl/snn_window_classifier_if.sv
// Sample/result bundle for the spiking window classifier.
// The slave side is the classifier core; the master side feeds samples.
interface snn_window_classifier_if #(
  parameter int NUM_NEURONS = 10,
  parameter int WIDTH_P     = 8,
  parameter int WINDOW_LEN  = 64
);
  localparam int CW = $clog2(NUM_NEURONS);
  localparam int SW = $clog2(WINDOW_LEN + 1);

  logic                   start_i;
  logic [WIDTH_P-1:0]     data_i;
  logic                   data_valid_i;
  logic                   busy_o;
  logic                   done_o;
  logic [CW-1:0]          class_o;
  logic [SW-1:0]          score_o;
  logic [NUM_NEURONS-1:0] spikes_o;

  modport slave (
    input  start_i, data_i, data_valid_i,
    output busy_o, done_o, class_o, score_o, spikes_o
  );

  modport master (
    output start_i, data_i, data_valid_i,
    input  busy_o, done_o, class_o, score_o, spikes_o
  );
endinterface

// File: rtl/snn_window_classifier.sv
// Adaptive-threshold LIF neuron bank with per-window spike counting
// and a sequential strict-greater argmax readout.
module snn_window_classifier #(
  parameter int NUM_NEURONS   = 10,
  parameter int WIDTH_P       = 8,
  parameter int WINDOW_LEN    = 64,
  parameter logic [4*NUM_NEURONS-1:0] WEIGHTS = {NUM_NEURONS{4'd1}},
  parameter int THRESHOLD     = 128,
  parameter int THRESHOLD_INC = 20,
  parameter int THRESHOLD_DEC = 1,
  parameter int THRESHOLD_MIN = 75,
  parameter int LEAK_SHIFT    = 3
) (
  input logic clk_i,
  input logic rst_ni,
  snn_window_classifier_if.slave bus
);
  localparam int VW = WIDTH_P + 1;
  localparam int PW = WIDTH_P + 4;
  localparam int CW = $clog2(NUM_NEURONS);
  localparam int SW = $clog2(WINDOW_LEN + 1);

  localparam logic [VW-1:0] THR_INIT = VW'(THRESHOLD);
  localparam logic [VW-1:0] THR_MIN  = VW'(THRESHOLD_MIN);
  localparam logic [VW-1:0] DEC_V    = VW'(THRESHOLD_DEC);
  localparam logic [VW:0]   INC_X    = (VW+1)'(THRESHOLD_INC);
  localparam logic [VW:0]   FLOOR_X  =
    (VW+1)'(THRESHOLD_MIN + THRESHOLD_DEC);

  typedef enum logic [1:0] {
    S_IDLE, S_RUN, S_SCAN, S_DONE
  } state_t;

  state_t r_state;

  logic [VW-1:0] r_v   [NUM_NEURONS];
  logic [VW-1:0] r_thr [NUM_NEURONS];
  logic [SW-1:0] r_cnt [NUM_NEURONS];

  logic [SW-1:0] r_nsmp;
  logic [CW-1:0] r_idx;
  logic [CW-1:0] r_best_cls;
  logic [SW-1:0] r_best;

  logic [VW-1:0] w_s      [NUM_NEURONS];
  logic [VW-1:0] w_thr_hi [NUM_NEURONS];
  logic [VW-1:0] w_thr_lo [NUM_NEURONS];
  logic [NUM_NEURONS-1:0] w_spk;

  logic w_start;
  logic w_acc;
  logic w_last;

  assign w_start = (r_state == S_IDLE) && bus.start_i;
  assign w_acc   = (r_state == S_RUN) && bus.data_valid_i;
  assign w_last  = w_acc && (r_nsmp == SW'(WINDOW_LEN - 1));

  for (genvar g = 0; g < NUM_NEURONS; g++) begin : g_nrn
    logic [PW-1:0]      w_prod;
    logic [WIDTH_P-1:0] w_cur;
    logic [VW:0]        w_sum;
    logic [VW:0]        w_thr_up;

    assign w_prod = PW'(bus.data_i) * PW'(WEIGHTS[4*g +: 4]);
    assign w_cur  = |w_prod[PW-1:WIDTH_P] ? '1
                  : w_prod[WIDTH_P-1:0];
    assign w_sum  = {1'b0, r_v[g] - (r_v[g] >> LEAK_SHIFT)}
                  + {2'b0, w_cur};
    assign w_s[g] = w_sum[VW] ? '1 : w_sum[VW-1:0];
    assign w_spk[g] = w_s[g] >= r_thr[g];

    assign w_thr_up    = {1'b0, r_thr[g]} + INC_X;
    assign w_thr_hi[g] = w_thr_up[VW] ? '1 : w_thr_up[VW-1:0];
    // Floor compare done one bit wider so thr < DEC cannot wrap
    assign w_thr_lo[g] = ({1'b0, r_thr[g]} >= FLOOR_X)
                       ? r_thr[g] - DEC_V : THR_MIN;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        r_v[i]   <= '0;
        r_thr[i] <= THR_INIT;
        r_cnt[i] <= '0;
      end
    end else if (w_start) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        r_v[i]   <= '0;
        r_thr[i] <= THR_INIT;
        r_cnt[i] <= '0;
      end
    end else if (w_acc) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        if (w_spk[i]) begin
          r_v[i]   <= '0;
          r_thr[i] <= w_thr_hi[i];
          r_cnt[i] <= r_cnt[i] + SW'(1);
        end else begin
          r_v[i]   <= w_s[i];
          r_thr[i] <= w_thr_lo[i];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= S_IDLE;
      r_nsmp       <= '0;
      r_idx        <= '0;
      r_best       <= '0;
      r_best_cls   <= '0;
      bus.busy_o   <= 1'b0;
      bus.done_o   <= 1'b0;
      bus.class_o  <= '0;
      bus.score_o  <= '0;
      bus.spikes_o <= '0;
    end else begin
      bus.done_o   <= 1'b0;
      bus.spikes_o <= w_acc ? w_spk : '0;
      unique case (r_state)
        S_IDLE: begin
          if (bus.start_i) begin
            r_state    <= S_RUN;
            r_nsmp     <= '0;
            bus.busy_o <= 1'b1;
          end
        end
        S_RUN: begin
          if (w_acc) r_nsmp <= r_nsmp + SW'(1);
          if (w_last) begin
            r_state    <= S_SCAN;
            r_idx      <= '0;
            r_best     <= '0;
            r_best_cls <= '0;
          end
        end
        S_SCAN: begin
          // Strict compare keeps the lowest index on ties
          if (r_cnt[r_idx] > r_best) begin
            r_best     <= r_cnt[r_idx];
            r_best_cls <= r_idx;
          end
          r_idx <= r_idx + CW'(1);
          if (r_idx == CW'(NUM_NEURONS - 1)) begin
            r_state    <= S_DONE;
            bus.busy_o <= 1'b0;
          end
        end
        S_DONE: begin
          bus.class_o <= r_best_cls;
          bus.score_o <= r_best;
          bus.done_o  <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_snn_window_classifier.sv
// Scoreboard bench: two classifier instances with different gains
// share one stimulus stream; a negedge monitor checks every output.
module tb_snn_window_classifier;
  localparam int NN = 10;
  localparam int WL = 8;
  localparam logic [4*NN-1:0] WA = 40'h11_1111_2111;
  localparam logic [4*NN-1:0] WB = 40'h11_1111_111F;

  typedef struct {
    int cls;
    int score;
    int tick;
    int blen;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tick = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  res_t q_ra[$];
  res_t q_rb[$];
  logic [NN-1:0] q_sa[$];
  logic [NN-1:0] q_sb[$];

  int mv   [2][NN];
  int mthr [2][NN];
  int mc   [2][NN];
  int blen [2];
  int lastb[2];

  always #5 clk = ~clk;
  always @(posedge clk) tick <= tick + 1;

  snn_window_classifier_if #(
    .NUM_NEURONS(NN), .WIDTH_P(8), .WINDOW_LEN(WL)
  ) ifa ();
  snn_window_classifier_if #(
    .NUM_NEURONS(NN), .WIDTH_P(8), .WINDOW_LEN(WL)
  ) ifb ();

  snn_window_classifier #(
    .NUM_NEURONS(NN), .WIDTH_P(8), .WINDOW_LEN(WL),
    .WEIGHTS(WA)
  ) dut_a (.clk_i(clk), .rst_ni(rst_n), .bus(ifa));

  snn_window_classifier #(
    .NUM_NEURONS(NN), .WIDTH_P(8), .WINDOW_LEN(WL),
    .WEIGHTS(WB)
  ) dut_b (.clk_i(clk), .rst_ni(rst_n), .bus(ifb));

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int wt(input int u, input int n);
    if (u == 0) return (n == 3) ? 2 : 1;
    return (n == 0) ? 15 : 1;
  endfunction

  function automatic int dat(input int mode, input int j);
    case (mode)
      0: return 0;
      1: return 64;
      2: return 255;
      3: return (j * 53 + 17) % 256;
      default: return 200;
    endcase
  endfunction

  task automatic mreset();
    for (int u = 0; u < 2; u++)
      for (int n = 0; n < NN; n++) begin
        mv[u][n] = 0;
        mthr[u][n] = 128;
        mc[u][n] = 0;
      end
  endtask

  task automatic mstep(input int u, input int d,
                       output logic [NN-1:0] spk);
    spk = '0;
    for (int n = 0; n < NN; n++) begin
      int cur;
      int s;
      cur = d * wt(u, n);
      if (cur > 255) cur = 255;
      s = mv[u][n] - mv[u][n] / 8 + cur;
      if (s > 511) s = 511;
      if (s >= mthr[u][n]) begin
        spk[n] = 1'b1;
        mv[u][n] = 0;
        mthr[u][n] = (mthr[u][n] + 20 > 511) ? 511 : mthr[u][n] + 20;
        mc[u][n]++;
      end else begin
        mv[u][n] = s;
        mthr[u][n] = (mthr[u][n] - 1 < 75) ? 75 : mthr[u][n] - 1;
      end
    end
  endtask

  task automatic drive(input bit st, input int d,
                       input bit v, input bit acc);
    logic [NN-1:0] sa;
    logic [NN-1:0] sb;
    ifa.start_i = st;
    ifb.start_i = st;
    ifa.data_i = 8'(d);
    ifb.data_i = 8'(d);
    ifa.data_valid_i = v;
    ifb.data_valid_i = v;
    @(posedge clk);
    sa = '0;
    sb = '0;
    if (acc) begin
      mstep(0, d, sa);
      mstep(1, d, sb);
    end
    q_sa.push_back(sa);
    q_sb.push_back(sb);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_a_busy"},  ifa.busy_o,   0);
    chk({tag, "_a_done"},  ifa.done_o,   0);
    chk({tag, "_a_class"}, ifa.class_o,  0);
    chk({tag, "_a_score"}, ifa.score_o,  0);
    chk({tag, "_a_spk"},   ifa.spikes_o, 0);
    chk({tag, "_b_busy"},  ifb.busy_o,   0);
    chk({tag, "_b_done"},  ifb.done_o,   0);
    chk({tag, "_b_class"}, ifb.class_o,  0);
    chk({tag, "_b_score"}, ifb.score_o,  0);
    chk({tag, "_b_spk"},   ifb.spikes_o, 0);
  endtask

  function automatic res_t best(input int u);
    res_t r;
    r.cls = 0;
    r.score = 0;
    for (int n = 0; n < NN; n++)
      if (mc[u][n] > r.score) begin
        r.score = mc[u][n];
        r.cls = n;
      end
    return r;
  endfunction

  // hand values < 0 fall back to the model result
  task automatic run(input int mode, input bit gap, input bit poke,
                     input int abort_at,
                     input int ca, input int sa,
                     input int cb, input int sb);
    int t0;
    int acc;
    int k;
    bit v;
    res_t ra;
    res_t rb;
    mreset();
    drive(1'b1, 255, 1'b1, 1'b0);
    t0 = tick;
    acc = 0;
    k = 0;
    while (acc < WL) begin
      v = gap ? (k % 2 == 0) : 1'b1;
      drive(poke && k == 2, dat(mode, acc), v, v);
      if (v) acc++;
      k++;
      if (abort_at > 0 && acc == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk_zero("abort");
        q_sa.delete();
        q_sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        return;
      end
    end
    ra = best(0);
    rb = best(1);
    if (ca >= 0) begin
      ra.cls = ca;
      ra.score = sa;
    end
    if (cb >= 0) begin
      rb.cls = cb;
      rb.score = sb;
    end
    ra.tick = t0 + k + 11;
    rb.tick = t0 + k + 11;
    ra.blen = k + 10;
    rb.blen = k + 10;
    q_ra.push_back(ra);
    q_rb.push_back(rb);
    for (int j = 0; j <= 10; j++)
      drive(poke && j == 3, 165, 1'b1, 1'b0);
  endtask

  task automatic check_done(input int u, input int cls, input int sc);
    res_t r;
    string p;
    p = (u == 0) ? "a_" : "b_";
    if ((u == 0 ? q_ra.size() : q_rb.size()) == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %sunexpected_done: got 1 expected 0", p);
      return;
    end
    r = (u == 0) ? q_ra.pop_front() : q_rb.pop_front();
    chk({p, "class"}, cls, r.cls);
    chk({p, "score"}, sc, r.score);
    chk({p, "done_cycle"}, tick, r.tick);
    chk({p, "busy_len"}, lastb[u], r.blen);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      blen[0] = 0;
      blen[1] = 0;
    end else begin
      if (q_sa.size() > 0) chk("a_spikes", ifa.spikes_o, q_sa.pop_front());
      if (q_sb.size() > 0) chk("b_spikes", ifb.spikes_o, q_sb.pop_front());
      if (ifa.busy_o) blen[0]++;
      else if (blen[0] > 0) begin
        lastb[0] = blen[0];
        blen[0] = 0;
      end
      if (ifb.busy_o) blen[1]++;
      else if (blen[1] > 0) begin
        lastb[1] = blen[1];
        blen[1] = 0;
      end
      if (ifa.done_o) check_done(0, ifa.class_o, ifa.score_o);
      if (ifb.done_o) check_done(1, ifb.class_o, ifb.score_o);
    end
  end

  initial begin
    blen[0] = 0;
    blen[1] = 0;
    lastb[0] = 0;
    lastb[1] = 0;
    ifa.start_i = 1'b0;
    ifb.start_i = 1'b0;
    ifa.data_i = '0;
    ifb.data_i = '0;
    ifa.data_valid_i = 1'b0;
    ifb.data_valid_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;

    run(0, 1'b0, 1'b0, 0, 0, 0, 0, 0);
    run(1, 1'b0, 1'b0, 0, 3, 4, 0, 7);
    run(2, 1'b0, 1'b1, 0, 0, 7, 0, 7);
    run(4, 1'b1, 1'b0, 0, 3, 7, 0, 7);
    run(3, 1'b0, 1'b0, 0, -1, 0, -1, 0);
    run(1, 1'b0, 1'b0, 5, 0, 0, 0, 0);
    drive(1'b0, 0, 1'b0, 1'b0);
    run(1, 1'b0, 1'b0, 0, 3, 4, 0, 7);
    repeat (3) drive(1'b0, 0, 1'b0, 1'b0);
    @(negedge clk);
    chk("a_pending", q_ra.size(), 0);
    chk("b_pending", q_rb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
